// File: rtl/btn_conditioner.sv
// btn_conditioner: synchronise, debounce and edge-detect start/randomize buttons.
// Optional randomize auto-repeat is built when BTN_AUTOREPEAT_EN is defined.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en,
   input  logic s,
   output logic press,
   output logic held
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] CMAX = '1;
   localparam logic [CW-1:0] ONE  = CW'(1);

   // ARMING: a button held through reset must read 0 before a press counts
   typedef enum logic [2:0] {
      ARMING,
      RELEASED,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } state_t;

   state_t        state;
   logic [CW-1:0] count;
   logic [CW-1:0] count_inc;

   assign count_inc = (count == CMAX) ? count : count + ONE;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ARMING;
         count <= '0;
         press <= 1'b0;
         held  <= 1'b0;
      end else begin
         press <= 1'b0;
         if (en) begin
            unique case (state)
               ARMING: begin
                  if (s) begin
                     count <= '0;
                  end else if (count == LAST) begin
                     state <= RELEASED;
                     count <= '0;
                  end else begin
                     count <= count_inc;
                  end
               end
               RELEASED: begin
                  if (s) begin
                     state <= PRESS_WAIT;
                     count <= ONE;
                  end
               end
               PRESS_WAIT: begin
                  if (!s) begin
                     state <= RELEASED;
                     count <= '0;
                  end else if (count == LAST) begin
                     state <= PRESSED;
                     count <= '0;
                     press <= 1'b1;
                     held  <= 1'b1;
                  end else begin
                     count <= count_inc;
                  end
               end
               PRESSED: begin
                  if (!s) begin
                     state <= RELEASE_WAIT;
                     count <= ONE;
                  end
               end
               RELEASE_WAIT: begin
                  if (s) begin
                     state <= PRESSED;
                     count <= '0;
                  end else if (count == LAST) begin
                     state <= RELEASED;
                     count <= '0;
                     held  <= 1'b0;
                  end else begin
                     count <= count_inc;
                  end
               end
               default: begin
                  state <= ARMING;
                  count <= '0;
                  held  <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

module btn_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int REPEAT_CYCLES   = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_start_raw,
   input  logic btn_rand_raw,
   output logic start,
   output logic randomize,
   output logic start_held,
   output logic rand_held
);
   if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
      $error("DEBOUNCE_CYCLES out of range");
   end
   if (REPEAT_CYCLES < 2) begin : g_bad_rep
      $error("REPEAT_CYCLES out of range");
   end

   logic [1:0] sync_s;
   logic [1:0] sync_r;
   logic [1:0] vld;
   logic       press_s;
   logic       press_r;
   logic       held_s;
   logic       held_r;
   logic       rand_ev;

   // vld masks the two cycles the synchronisers still hold reset values
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_s <= '0;
         sync_r <= '0;
         vld    <= '0;
      end else begin
         sync_s <= {sync_s[0], btn_start_raw};
         sync_r <= {sync_r[0], btn_rand_raw};
         vld    <= {vld[0], 1'b1};
      end
   end

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (vld[1]),
      .s       (sync_s[1]),
      .press   (press_s),
      .held    (held_s)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rand (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (vld[1]),
      .s       (sync_r[1]),
      .press   (press_r),
      .held    (held_r)
   );

`ifdef BTN_AUTOREPEAT_EN
   localparam int RW = $clog2(REPEAT_CYCLES);
   localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);

   logic [RW-1:0] rep_cnt;
   logic          rep_fire;

   assign rep_fire = held_r && !press_r && (rep_cnt == RLAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rep_cnt <= '0;
      end else if (!held_r || press_r || rep_fire) begin
         rep_cnt <= '0;
      end else begin
         rep_cnt <= rep_cnt + RW'(1);
      end
   end

   assign rand_ev = press_r | rep_fire;
`else
   assign rand_ev = press_r;
`endif

   // start wins a same-cycle collision; the randomize event is dropped
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start      <= 1'b0;
         randomize  <= 1'b0;
         start_held <= 1'b0;
         rand_held  <= 1'b0;
      end else begin
         start      <= press_s;
         randomize  <= rand_ev & ~press_s;
         start_held <= held_s;
         rand_held  <= held_r;
      end
   end
endmodule
